// File: rtl/coproc_pkg.sv
// coproc_pkg: shared encodings, sizes and load-window helpers for the coprocessor host link
package coproc_pkg;
    localparam int NUM_ELEMS = 25;
    localparam int RESULT_WORDS = 7;
    localparam int TIMEOUT_CYC_DEF = 16;
    typedef enum logic [2:0] {
        CMD_NOP    = 3'b000,
        CMD_LOAD_A = 3'b001,
        CMD_LOAD_B = 3'b010,
        CMD_EXEC   = 3'b011
    } cmd_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_SEND = 2'b10
    } state_e;
    // True when element k lies in the three-element window starting at base.
    function automatic logic load_hit(int k, logic [4:0] base);
        return (6'(k) - {1'b0, base}) < 6'd3;
    endfunction
    function automatic logic [7:0] load_byte(logic [23:0] data, int k, logic [4:0] base);
        logic [1:0] s;
        s = 2'(6'(k) - {1'b0, base});
        return 8'(data >> {s, 3'b000});
    endfunction
endpackage

// File: rtl/coproc_result_serializer.sv
// coproc_result_serializer: packs the captured result into 7 readback words and walks them under res_ready
module coproc_result_serializer
    import coproc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         active,
    input  logic         res_ready,
    input  logic [199:0] result,
    input  logic         ovf,
    input  logic         tmo,
    output logic         res_valid,
    output logic [31:0]  res_data,
    output logic         last
);
    logic [2:0]   idx;
    logic [223:0] ext;
    // Word 6 falls out of the padded vector: element 24, then overflow, then timeout.
    assign ext = {22'b0, tmo, ovf, result};
    assign res_valid = active;
    assign last = active && res_ready && idx == 3'(RESULT_WORDS - 1);
    assign res_data = active ? ext[{idx, 5'b0} +: 32] : '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) idx <= '0;
        else if (!active || last) idx <= '0;
        else if (res_ready) idx <= idx + 3'd1;
    end
endmodule

// File: rtl/coproc_host_link.sv
// coproc_host_link: host command decoder, operand registers and completion FSM for the matrix coprocessor
module coproc_host_link
    import coproc_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    input  logic [31:0]  cmd_data,
    output logic         cmd_ready,
    output logic [2:0]   op_code,
    output logic [1:0]   matrix_size,
    output logic [199:0] matrix_a,
    output logic [199:0] matrix_b,
    output logic [7:0]   scalar,
    input  logic [199:0] result_final,
    input  logic         overflow,
    input  logic         process_Done,
    output logic         res_valid,
    output logic [31:0]  res_data,
    input  logic         res_ready,
    output logic         busy
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    state_e       state, next;
    cmd_e         op;
    logic         accept, last, ovf_q, tmo_q;
    logic [4:0]   base;
    logic [CW-1:0] cnt;
    logic [199:0] res_q;
    assign op = cmd_e'(cmd_data[31:29]);
    assign base = cmd_data[28:24];
    assign cmd_ready = state == ST_IDLE;
    assign busy = state != ST_IDLE;
    assign accept = cmd_valid && cmd_ready;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else state <= next;
    end
    // cnt==0 marks the settle cycle; sampling of process_Done starts once it is 1.
    always_comb begin
        next = state;
        case (state)
            ST_IDLE: next = accept && op == CMD_EXEC ? ST_WAIT : ST_IDLE;
            ST_WAIT: next = cnt != '0 && (process_Done || cnt == CW'(TIMEOUT_CYC)) ? ST_SEND : ST_WAIT;
            ST_SEND: next = last ? ST_IDLE : ST_SEND;
            default: next = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            matrix_a <= '0;
            matrix_b <= '0;
            op_code <= '0;
            matrix_size <= '0;
            scalar <= '0;
            cnt <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
        end else begin
            if (accept && op == CMD_EXEC) begin
                op_code <= cmd_data[4:2];
                matrix_size <= cmd_data[1:0];
                scalar <= cmd_data[12:5];
                cnt <= '0;
            end
            for (int k = 0; k < NUM_ELEMS; k++) begin
                if (accept && op == CMD_LOAD_A && load_hit(k, base)) matrix_a[8*k +: 8] <= load_byte(cmd_data[23:0], k, base);
                if (accept && op == CMD_LOAD_B && load_hit(k, base)) matrix_b[8*k +: 8] <= load_byte(cmd_data[23:0], k, base);
            end
            if (state == ST_WAIT) begin
                if (cnt == '0) cnt <= CW'(1);
                else if (process_Done) begin
                    res_q <= result_final;
                    ovf_q <= overflow;
                    tmo_q <= 1'b0;
                end else if (cnt == CW'(TIMEOUT_CYC)) begin
                    res_q <= '0;
                    ovf_q <= 1'b0;
                    tmo_q <= 1'b1;
                end else cnt <= cnt + 1'b1;
            end
        end
    end
    coproc_result_serializer u_ser (
        .clk       (clk),
        .reset     (reset),
        .active    (state == ST_SEND),
        .res_ready (res_ready),
        .result    (res_q),
        .ovf       (ovf_q),
        .tmo       (tmo_q),
        .res_valid (res_valid),
        .res_data  (res_data),
        .last      (last)
    );
endmodule

// File: tb/tb_coproc_host_link.sv
// tb_coproc_host_link: directed bench for coproc_host_link with immediate-assertion checks
module tb_coproc_host_link;
    logic clk = 1'b0;
    logic reset, cmd_valid, res_ready, overflow, process_Done;
    logic [31:0] cmd_data, res_data;
    logic cmd_ready, res_valid, busy;
    logic [2:0] op_code;
    logic [1:0] matrix_size;
    logic [7:0] scalar;
    logic [199:0] matrix_a, matrix_b, result_final;
    logic [7:0] ea[25];
    logic [7:0] eb[25];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    coproc_host_link dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_ready(cmd_ready),
        .op_code(op_code), .matrix_size(matrix_size), .matrix_a(matrix_a), .matrix_b(matrix_b),
        .scalar(scalar), .result_final(result_final), .overflow(overflow), .process_Done(process_Done),
        .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [199:0] pk(input bit b);
        logic [199:0] p;
        for (int k = 0; k < 25; k++) p[8*k +: 8] = b ? eb[k] : ea[k];
        return p;
    endfunction

    function automatic logic [199:0] sum();
        logic [199:0] s;
        for (int k = 0; k < 25; k++) s[8*k +: 8] = ea[k] + eb[k];
        return s;
    endfunction

    function automatic logic [31:0] word(input logic [199:0] r, input logic o, input logic t, input int j);
        if (j == 6) return {22'b0, t, o, r[199:192]};
        return {r[8*(4*j+3) +: 8], r[8*(4*j+2) +: 8], r[8*(4*j+1) +: 8], r[8*(4*j) +: 8]};
    endfunction

    function automatic logic [7:0] el(input bit b, input int k);
        if (k > 24) return 8'hEE;
        return b ? eb[k] : ea[k];
    endfunction

    task automatic cmd(input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_data = d;
        tick();
        cmd_valid = 1'b0;
        cmd_data = '0;
    endtask

    task automatic load(input bit b, input int base);
        cmd({b ? 3'b010 : 3'b001, 5'(base), el(b, base + 2), el(b, base + 1), el(b, base)});
    endtask

    task automatic exec(input logic [2:0] op, input logic [1:0] sz, input logic [7:0] sc, input int exp_lat);
        int lat;
        cmd({3'b011, 16'b0, sc, op, sz});
        lat = 0;
        while (!res_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("latency", 200'(lat + 1), 200'(exp_lat));
        chk("exec_op", 200'(op_code), 200'(op));
        chk("exec_size", 200'(matrix_size), 200'(sz));
        chk("exec_scalar", 200'(scalar), 200'(sc));
        chk("exec_busy", 200'(busy), 200'd1);
        chk("exec_cmd_ready", 200'(cmd_ready), 200'd0);
    endtask

    task automatic read_words(input logic [199:0] r, input logic o, input logic t, input int from, input int to);
        for (int j = from; j <= to; j++) begin
            chk($sformatf("valid%0d", j), 200'(res_valid), 200'd1);
            chk($sformatf("word%0d", j), 200'(res_data), 200'(word(r, o, t, j)));
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cmd_ready"}, 200'(cmd_ready), 200'd1);
        chk({tag, "_busy"}, 200'(busy), 200'd0);
        chk({tag, "_res_valid"}, 200'(res_valid), 200'd0);
        chk({tag, "_res_data"}, 200'(res_data), 200'd0);
        chk({tag, "_matrix_a"}, matrix_a, 200'd0);
        chk({tag, "_matrix_b"}, matrix_b, 200'd0);
        chk({tag, "_op_code"}, 200'(op_code), 200'd0);
        chk({tag, "_matrix_size"}, 200'(matrix_size), 200'd0);
        chk({tag, "_scalar"}, 200'(scalar), 200'd0);
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_data = '0;
        res_ready = 1'b0;
        overflow = 1'b0;
        process_Done = 1'b0;
        result_final = '0;
        repeat (2) tick();
        chk_reset("rst");
        reset = 1'b0;
        tick();

        for (int k = 0; k < 25; k++) begin
            ea[k] = 8'(k + 1);
            eb[k] = 8'd2;
        end
        for (int b = 0; b < 25; b += 3) load(1'b0, b);
        for (int b = 0; b < 25; b += 3) load(1'b1, b);
        chk("load_a", matrix_a, pk(1'b0));
        chk("load_b", matrix_b, pk(1'b1));
        chk("load_a_word0", 200'(matrix_a[31:0]), 200'h04030201);
        chk("load_idle", 200'(busy), 200'd0);

        result_final = sum();
        process_Done = 1'b1;
        exec(3'b000, 2'b11, 8'h85, 3);
        chk("sum_word0_const", 200'(res_data), 200'h06050403);
        read_words(sum(), 1'b0, 1'b0, 0, 6);
        chk("done_valid", 200'(res_valid), 200'd0);
        chk("done_busy", 200'(busy), 200'd0);
        chk("done_ready", 200'(cmd_ready), 200'd1);

        ea[23] = 8'h0C;
        ea[24] = 8'h0B;
        cmd({3'b001, 5'd23, 24'h0A0B0C});
        chk("edge_load_a", matrix_a, pk(1'b0));
        chk("edge_load_b", matrix_b, pk(1'b1));

        process_Done = 1'b0;
        result_final = '1;
        exec(3'b010, 2'b01, 8'h10, 18);
        read_words(200'd0, 1'b0, 1'b1, 0, 6);

        process_Done = 1'b1;
        result_final = sum();
        exec(3'b101, 2'b01, 8'h7F, 3);
        read_words(sum(), 1'b0, 1'b0, 0, 1);
        for (int c = 0; c < 5; c++) begin
            cmd_valid = 1'b1;
            cmd_data = {3'b001, 5'd0, 24'h777777};
            tick();
            chk("stall_word2", 200'(res_data), 200'(word(sum(), 1'b0, 1'b0, 2)));
            chk("stall_cmd_ready", 200'(cmd_ready), 200'd0);
        end
        cmd_valid = 1'b0;
        cmd_data = '0;
        chk("stall_no_load", matrix_a, pk(1'b0));
        read_words(sum(), 1'b0, 1'b0, 2, 6);

        chk("rsvd_ready", 200'(cmd_ready), 200'd1);
        cmd(32'hBFFF_FFFF);
        chk("rsvd_busy", 200'(busy), 200'd0);
        chk("rsvd_ready_after", 200'(cmd_ready), 200'd1);
        chk("rsvd_op", 200'(op_code), 200'd5);
        chk("rsvd_size", 200'(matrix_size), 200'd1);
        chk("rsvd_scalar", 200'(scalar), 200'h7F);
        chk("rsvd_a", matrix_a, pk(1'b0));
        chk("rsvd_b", matrix_b, pk(1'b1));
        chk("rsvd_valid", 200'(res_valid), 200'd0);

        overflow = 1'b1;
        exec(3'b001, 2'b10, 8'h01, 3);
        read_words(sum(), 1'b1, 1'b0, 0, 6);

        exec(3'b011, 2'b00, 8'h22, 3);
        read_words(sum(), 1'b1, 1'b0, 0, 2);
        chk("pre_rst_word3", 200'(res_data), 200'(word(sum(), 1'b1, 1'b0, 3)));
        reset = 1'b1;
        #1;
        chk_reset("mid_rst");
        tick();
        reset = 1'b0;
        overflow = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post_rst_valid", 200'(res_valid), 200'd0);
            chk("post_rst_busy", 200'(busy), 200'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
